// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider with start/done handshake, one quotient bit per cycle.
// Define DIV_SIGNED_EN for two's-complement operands (sign-magnitude around the unsigned core).
module seq_divider #(
    parameter int M = 26,
    parameter int N = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [M-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {IDLE, CALC, ZERO, DONE} state_t;

    // Handshake: start is accepted on a rising edge only while state is IDLE or DONE;
    // done is a one-cycle pulse and results stay valid until the next done.
    state_t         state;
    state_t         state_nxt;
    logic           accept;
    logic [M-1:0]   d_q;
    logic [N-1:0]   dvs_q;
    logic [N:0]     p_q;
    logic [CW-1:0]  cnt_q;
    logic           last_iter;

    logic [M-1:0]   a_mag;
    logic [N-1:0]   b_mag;
    logic [N:0]     p_shift;
    logic [N:0]     p_sub;
    logic [N:0]     p_nxt;
    logic           q_bit;
    logic [M-1:0]   q_raw;
    logic [M-1:0]   q_fin;
    logic [N-1:0]   r_fin;

    assign accept    = start && (state == IDLE || state == DONE);
    assign busy      = (state == CALC) || (state == ZERO);
    assign done      = (state == DONE);
    assign last_iter = (cnt_q == CW'(M - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) state_nxt = (divisor == '0) ? ZERO : CALC;
                else       state_nxt = IDLE;
            end
            CALC:    if (last_iter) state_nxt = DONE;
            ZERO:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // D doubles as the quotient shift register: quotient bits enter at the LSB as dividend bits leave.
    always_comb begin
        p_shift = {p_q[N-1:0], d_q[M-1]};
        p_sub   = p_shift - {1'b0, dvs_q};
        q_bit   = (p_shift >= {1'b0, dvs_q});
        p_nxt   = q_bit ? p_sub : p_shift;
        q_raw   = {d_q[M-2:0], q_bit};
    end

`ifdef DIV_SIGNED_EN
    logic q_neg_q;
    logic r_neg_q;

    always_comb begin
        a_mag = dividend[M-1] ? (~dividend + M'(1)) : dividend;
        b_mag = divisor[N-1]  ? (~divisor + N'(1))  : divisor;
        q_fin = q_neg_q ? (~q_raw + M'(1)) : q_raw;
        r_fin = r_neg_q ? (~p_nxt[N-1:0] + N'(1)) : p_nxt[N-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
        end else if (accept) begin
            q_neg_q <= dividend[M-1] ^ divisor[N-1];
            r_neg_q <= dividend[M-1];
        end
    end
`else
    always_comb begin
        a_mag = dividend;
        b_mag = divisor;
        q_fin = q_raw;
        r_fin = p_nxt[N-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= '0;
            dvs_q       <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            d_q   <= a_mag;
            dvs_q <= b_mag;
            p_q   <= '0;
            cnt_q <= '0;
        end else if (state == CALC) begin
            d_q   <= q_raw;
            p_q   <= p_nxt;
            cnt_q <= cnt_q + CW'(1);
            if (last_iter) begin
                quotient    <= q_fin;
                remainder   <= r_fin;
                div_by_zero <= 1'b0;
            end
        end else if (state == ZERO) begin
            quotient    <= '1;
            remainder   <= '0;
            div_by_zero <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: randomized and directed divisions against an arithmetic reference model.
// Build with DIV_SIGNED_EN defined to exercise the two's-complement variant.
module tb_seq_divider;

    localparam int M = 26;
    localparam int N = 14;
    localparam int W = M + N + 1 + 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [M-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [M-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [W-1:0] exp_q[$];
    int           acc_q[$];

    seq_divider #(.M(M), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: {quotient, remainder, div_by_zero, latency}
    function automatic logic [W-1:0] model(input logic [M-1:0] a, input logic [N-1:0] b);
        longint qa, ra;
        logic [M-1:0] q;
        logic [N-1:0] r;
        if (b == '0) return {{M{1'b1}}, {N{1'b0}}, 1'b1, 8'd2};
`ifdef DIV_SIGNED_EN
        qa = longint'($signed(a)) / longint'($signed(b));
        ra = longint'($signed(a)) % longint'($signed(b));
`else
        qa = longint'(a) / longint'(b);
        ra = longint'(a) % longint'(b);
`endif
        q = M'(qa);
        r = N'(ra);
        return {q, r, 1'b0, 8'(M + 1)};
    endfunction

    // driver: present start while the DUT can accept; the period ending at the accept edge is cycle 0
    task automatic issue(input logic [M-1:0] a, input logic [N-1:0] b);
        int waited = 0;
        @(negedge clk);
        while (busy && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            check("issue_timeout", 1, 0);
            return;
        end
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        exp_q.push_back(model(a, b));
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = $urandom();
        divisor  = N'($urandom());
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        int a;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("quotient", quotient, e[W-1 -: M]);
                check("remainder", remainder, e[N+8 -: N]);
                check("div_by_zero", div_by_zero, e[8]);
                check("latency", cyc - a, e[7:0]);
                check("busy_at_done", busy, 0);
            end
        end
    end

    initial begin
        int done_cnt;
        int guard;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        issue(M'(67092480), N'(3));
        issue(M'(26'h3FFFFFF), N'(14'h3FFF));
        issue(M'(26'h3FFFFFF), N'(1));
        issue(M'(100), N'(0));
        issue(M'(100), N'(7));

        // start during CALC is ignored
        issue(M'(100), N'(7));
        repeat (9) @(negedge clk);
        start = 1'b1; dividend = M'(5); divisor = N'(1);
        repeat (3) @(negedge clk);
        start = 1'b0;

        // back-to-back: second start is held through DONE of the first
        issue(M'(100), N'(7));
        issue(M'(5), N'(1));
        issue(M'(7), N'(0));
        issue(M'(9), N'(4));

`ifdef DIV_SIGNED_EN
        issue(M'(-100), N'(7));
        issue(M'(100), N'(-7));
        issue(26'h2000000, {N{1'b1}});
        issue(M'(-100), N'(-7));
`endif

        // randomized
        for (int i = 0; i < 24; i++) begin
            logic [M-1:0] a;
            logic [N-1:0] b;
            a = M'($urandom());
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = N'($urandom_range(1, 15));
                default: b = N'($urandom());
            endcase
            issue(a, b);
        end

        // reset mid-operation
        issue(M'(1000), N'(3));
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_dbz", div_by_zero, 0);
        exp_q.delete();
        acc_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("no_done_after_abort", done_cnt, 0);
        issue(M'(100), N'(7));

        // drain
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
